rf_multiport: RTL and testbench

Parametrised register file that generalises the core's 16x16 two-read/priority-write register file. Width, depth and read/write port counts are configurable, with per-port priority on address collision, optional write-to-read bypass and an optional hardwired zero register. After every reset a built-in clear sequencer zeroes all entries, one per cycle, before the file accepts traffic. The block sits in the decode/writeback stage: the PC-update path drives write port 0 and ALU writeback drives port 1.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_init_seq.sv | 64 ++++++
 rtl/rf_multiport.sv | 93 +++++++++
 tb/tb_rf_multiport.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the multiport register file.
// Sized by DATA_W/DEPTH; AW derives from DEPTH.
package rf_pkg;

  typedef enum logic {
    INIT,
    RUN
  } rf_state_t;

  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 16;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset clear sequencer: zeroes one entry per cycle,
// then raises ready. Flags writes attempted while clearing.
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_WR = 2,
  localparam int AW    = rf_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_WR-1:0] wr_en,
  output logic              clr_we,
  output logic [AW-1:0]     clr_addr,
  output logic              ready,
  output logic              wr_drop
);

  rf_state_t     state, state_n;
  logic [AW-1:0] clr_ptr, clr_ptr_n;
  logic          ready_n, drop_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_ptr <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_n;
      clr_ptr <= clr_ptr_n;
      ready   <= ready_n;
      wr_drop <= drop_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_ptr_n = clr_ptr;
    ready_n   = ready;
    drop_n    = 1'b0;
    clr_we    = 1'b0;
    unique case (state)
      INIT: begin
        clr_we    = 1'b1;
        clr_ptr_n = clr_ptr + AW'(1);
        drop_n    = |wr_en;
        if (clr_ptr == AW'(DEPTH - 1)) begin
          state_n = RUN;
          ready_n = 1'b1;
        end
      end
      RUN: begin
        ready_n = 1'b1;
      end
      default: begin
        state_n = INIT;
      end
    endcase
  end

  assign clr_addr = clr_ptr;

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multiport register file with priority writes,
// optional write-to-read bypass and optional zero register.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     ready,
  output logic                     wr_drop
);

  logic                    clr_we;
  logic [AW-1:0]           clr_addr;
  logic [DEPTH*DATA_W-1:0] mem_flat;

  rf_init_seq #(
    .DEPTH (DEPTH),
    .NUM_WR(NUM_WR)
  ) u_init (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .ready   (ready),
    .wr_drop (wr_drop)
  );

  // Descending scan so the lowest-index matching port wins.
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic              we;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] q;

    always_comb begin
      we = 1'b0;
      wd = '0;
      if (clr_we) begin
        we = (clr_addr == AW'(e));
      end else if (!(ZERO_REG != 0 && e == 0)) begin
        for (int p = NUM_WR - 1; p >= 0; p--) begin
          if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(e)) begin
            we = 1'b1;
            wd = wr_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (we) q <= wd;
    end

    assign mem_flat[e*DATA_W +: DATA_W] = q;
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;

    assign a = rd_addr[r*AW +: AW];

    always_comb begin
      d = '0;
      if (rd_en[r] && ready && !(ZERO_REG != 0 && a == '0)) begin
        d = mem_flat[int'(a)*DATA_W +: DATA_W];
        if (BYPASS != 0) begin
          for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (wr_en[p] && wr_addr[p*AW +: AW] == a)
              d = wr_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end

    assign rd_data[r*DATA_W +: DATA_W] = d;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: default, no-bypass and
// 32x32 zero-register configurations share clock and reset.
module tb_rf_multiport;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  a_wr_en, a_rd_en;
  logic [7:0]  a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;
  logic        a_ready, a_wr_drop;

  logic [1:0]  b_wr_en, b_rd_en;
  logic [7:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data;
  logic        b_ready, b_wr_drop;

  logic [1:0]  c_wr_en;
  logic [2:0]  c_rd_en;
  logic [9:0]  c_wr_addr;
  logic [14:0] c_rd_addr;
  logic [63:0] c_wr_data;
  logic [95:0] c_rd_data;
  logic        c_ready, c_wr_drop;

  rf_multiport dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .ready(a_ready), .wr_drop(a_wr_drop)
  );

  rf_multiport #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .ready(b_ready), .wr_drop(b_wr_drop)
  );

  rf_multiport #(
    .DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .ready(c_ready), .wr_drop(c_wr_drop)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_rd_en = 2'b11;
    a_rd_addr = 8'h00;
    tick;
    tick;
    n_cmp++;
    if (a_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", a_ready);
    end
    n_cmp++;
    if (a_wr_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_wr_drop: got %b want 0", a_wr_drop);
    end
    n_cmp++;
    if (a_rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rd_data: got %h want 0", a_rd_data);
    end
    n_cmp++;
    if (c_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_c_ready: got %b want 0", c_ready);
    end
  endtask

  task automatic test_clear_init_write;
    rst_n = 1'b1;
    a_rd_en = 2'b11;
    a_rd_addr = {4'd3, 4'd3};
    for (int k = 1; k <= 16; k++) begin
      tick;
      n_cmp++;
      if (a_ready !== (k == 16)) begin
        n_bad++;
        $display("FAIL clear_ready k=%0d: got %b want %b",
                 k, a_ready, (k == 16));
      end
      if (k < 16) begin
        n_cmp++;
        if (a_rd_data !== 32'h0) begin
          n_bad++;
          $display("FAIL init_read k=%0d: got %h want 0",
                   k, a_rd_data);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (a_wr_drop !== 1'b1) begin
          n_bad++;
          $display("FAIL init_wr_drop: got %b want 1", a_wr_drop);
        end
        a_wr_en = 2'b00;
      end
      if (k == 6) begin
        n_cmp++;
        if (a_wr_drop !== 1'b0) begin
          n_bad++;
          $display("FAIL wr_drop_sticky: got %b want 0", a_wr_drop);
        end
      end
      if (k == 4) begin
        a_wr_en = 2'b10;
        a_wr_addr = {4'd3, 4'd0};
        a_wr_data = {16'hBEEF, 16'h0000};
      end
    end
    b_rd_en = 2'b11;
    for (int i = 0; i < 16; i++) begin
      a_rd_addr = {i[3:0], i[3:0]};
      b_rd_addr = {i[3:0], i[3:0]};
      #1;
      n_cmp++;
      if (a_rd_data !== 32'h0 || b_rd_data !== 32'h0) begin
        n_bad++;
        $display("FAIL clear_scan addr=%0d: got %h/%h want 0/0",
                 i, a_rd_data, b_rd_data);
      end
    end
  endtask

  task automatic test_collision;
    tick;
    a_wr_en = 2'b11;
    a_wr_addr = {4'd7, 4'd7};
    a_wr_data = {16'h2222, 16'h1111};
    a_rd_en = 2'b10;
    a_rd_addr = {4'd7, 4'd0};
    #1;
    n_cmp++;
    if (a_rd_data !== {16'h1111, 16'h0000}) begin
      n_bad++;
      $display("FAIL collision_bypass: got %h want 11110000",
               a_rd_data);
    end
    tick;
    a_wr_en = 2'b00;
    a_rd_en = 2'b01;
    a_rd_addr = {4'd0, 4'd7};
    #1;
    n_cmp++;
    if (a_rd_data !== {16'h0000, 16'h1111}) begin
      n_bad++;
      $display("FAIL collision_winner: got %h want 00001111",
               a_rd_data);
    end
    n_cmp++;
    if (a_wr_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_wr_drop: got %b want 0", a_wr_drop);
    end
    a_wr_en = 2'b11;
    a_wr_addr = {4'd6, 4'd5};
    a_wr_data = {16'h0606, 16'h0505};
    tick;
    a_wr_en = 2'b00;
    a_rd_en = 2'b11;
    a_rd_addr = {4'd6, 4'd5};
    #1;
    n_cmp++;
    if (a_rd_data !== {16'h0606, 16'h0505}) begin
      n_bad++;
      $display("FAIL distinct_writes: got %h want 06060505",
               a_rd_data);
    end
  endtask

  task automatic test_bypass;
    tick;
    a_wr_en = 2'b10;
    a_wr_addr = {4'd4, 4'd0};
    a_wr_data = {16'hA5A5, 16'h0000};
    a_rd_en = 2'b01;
    a_rd_addr = {4'd0, 4'd4};
    b_wr_en = a_wr_en;
    b_wr_addr = a_wr_addr;
    b_wr_data = a_wr_data;
    b_rd_en = a_rd_en;
    b_rd_addr = a_rd_addr;
    #1;
    n_cmp++;
    if (a_rd_data !== 32'h0000_A5A5) begin
      n_bad++;
      $display("FAIL bypass_on: got %h want 0000a5a5", a_rd_data);
    end
    n_cmp++;
    if (b_rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL bypass_off: got %h want 0", b_rd_data);
    end
    tick;
    a_wr_en = 2'b00;
    b_wr_en = 2'b00;
    #1;
    n_cmp++;
    if (b_rd_data !== 32'h0000_A5A5) begin
      n_bad++;
      $display("FAIL nobypass_latency: got %h want 0000a5a5",
               b_rd_data);
    end
  endtask

  task automatic test_zero_reg;
    for (int i = 0; i < 64 && !c_ready; i++) tick;
    n_cmp++;
    if (c_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL c_ready_timeout: got %b want 1", c_ready);
    end
    tick;
    c_wr_en = 2'b11;
    c_wr_addr = {5'd31, 5'd0};
    c_wr_data = {32'hDEADBEEF, 32'hDEADBEEF};
    c_rd_en = 3'b111;
    c_rd_addr = {5'd0, 5'd0, 5'd0};
    #1;
    n_cmp++;
    if (c_rd_data !== 96'h0) begin
      n_bad++;
      $display("FAIL zero_bypass: got %h want 0", c_rd_data);
    end
    tick;
    c_wr_en = 2'b00;
    #1;
    n_cmp++;
    if (c_rd_data !== 96'h0) begin
      n_bad++;
      $display("FAIL zero_read: got %h want 0", c_rd_data);
    end
    n_cmp++;
    if (c_wr_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_wr_drop: got %b want 0", c_wr_drop);
    end
    c_rd_addr = {5'd31, 5'd31, 5'd31};
    #1;
    n_cmp++;
    if (c_rd_data !== {3{32'hDEADBEEF}}) begin
      n_bad++;
      $display("FAIL wide_read: got %h want 3x deadbeef", c_rd_data);
    end
    c_rd_en = 3'b101;
    #1;
    n_cmp++;
    if (c_rd_data !== {32'hDEADBEEF, 32'h0, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL rd_en_gate: got %h want deadbeef_0_deadbeef",
               c_rd_data);
    end
  endtask

  task automatic test_reset_mid;
    tick;
    a_wr_en = 2'b10;
    a_wr_addr = {4'd9, 4'd0};
    a_wr_data = {16'h00FF, 16'h0000};
    tick;
    a_wr_en = 2'b00;
    a_rd_en = 2'b01;
    a_rd_addr = {4'd0, 4'd9};
    #1;
    n_cmp++;
    if (a_rd_data !== 32'h0000_00FF) begin
      n_bad++;
      $display("FAIL pre_reset_fill: got %h want 000000ff", a_rd_data);
    end
    tick;
    rst_n = 1'b0;
    tick;
    n_cmp++;
    if (a_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_ready: got %b want 0", a_ready);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick;
      n_cmp++;
      if (a_ready !== (k == 16)) begin
        n_bad++;
        $display("FAIL reclear_ready k=%0d: got %b want %b",
                 k, a_ready, (k == 16));
      end
    end
    n_cmp++;
    if (a_rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reclear_addr9: got %h want 0", a_rd_data);
    end
    a_wr_en = 2'b01;
    a_wr_addr = {4'd0, 4'd2};
    a_wr_data = {16'h0000, 16'h1234};
    tick;
    a_wr_en = 2'b00;
    a_rd_addr = {4'd0, 4'd2};
    #1;
    n_cmp++;
    if (a_rd_data !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL first_ready_write: got %h want 00001234",
               a_rd_data);
    end
  endtask

  initial begin
    a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_rd_en = '0; a_rd_addr = '0;
    b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rd_en = '0; b_rd_addr = '0;
    c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0;
    c_rd_en = '0; c_rd_addr = '0;
    test_reset;
    test_clear_init_write;
    test_collision;
    test_bypass;
    test_zero_reg;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
